bus_arbiter_rr: RTL and testbench

//  Round-robin arbiter for the shared CPU bus. Takes one request line per bus driver and issues a one-hot grant.
//  The one-hot grant feeds encoder_32_5 directly; a matching 5-bit index is also provided.
//  The grant is held until the owner drops its request.
//  A turnaround gap between owners prevents two drivers being on the bus at once.

---
 rtl/bus_arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 44 ++++
 rtl/bus_arbiter_rr.sv | 142 ++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared state encoding, widths and index helper for bus_arbiter_rr
package bus_arb_pkg;

  localparam int IDX_W   = 5;
  localparam int GRANT_W = 32;

  localparam logic [IDX_W-1:0] IDX_NONE = 5'd31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_e;

  // Next round-robin start point: one past idx, wrapping to 0 after the last requester.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx,
                                                input logic [IDX_W-1:0] last);
    return (idx == last) ? '0 : idx + 5'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: rotate by ptr, lowest-set priority, rotate back
module rr_pick import bus_arb_pkg::*; #(
  parameter int NREQ = 24
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  win,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  localparam logic [IDX_W:0] NREQ_W = (IDX_W+1)'(NREQ);

  logic [2*NREQ-1:0] dbl_req;
  logic [2*NREQ-1:0] dbl_pick;
  logic [NREQ-1:0]   rot_req;
  logic [NREQ-1:0]   pick;
  logic [IDX_W-1:0]  pick_off;
  logic [IDX_W:0]    idx_sum;

  always_comb begin
    dbl_req  = {req, req};
    rot_req  = NREQ'(dbl_req >> ptr);
    pick     = '0;
    pick_off = '0;
    any      = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (rot_req[i] && !any) begin
        pick[i]  = 1'b1;
        pick_off = IDX_W'(i);
        any      = 1'b1;
      end
    end
    // Rotating the doubled one-hot left by ptr lands the winner in the upper half.
    dbl_pick = {pick, pick} << ptr;
    win      = dbl_pick[2*NREQ-1:NREQ];
    idx_sum  = {1'b0, ptr} + {1'b0, pick_off};
    if (idx_sum >= NREQ_W) begin
      idx_sum = idx_sum - NREQ_W;
    end
    win_idx = any ? idx_sum[IDX_W-1:0] : IDX_NONE;
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - round-robin bus arbiter with hold-until-release and turnaround gap
// Optional hold timeout enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter_rr import bus_arb_pkg::*; #(
  parameter int NREQ        = 24,
  parameter int TURN_CYCLES = 1,
  parameter int MAX_HOLD    = 16
) (
  input  logic               clk,
  input  logic               clear,
  input  logic [NREQ-1:0]    req,
  output logic [GRANT_W-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid,
  output logic               timeout_err
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NREQ - 1);
  localparam logic [2:0]       TURN_LAST = 3'(TURN_CYCLES - 1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [2:0]         turn_cnt_q, turn_cnt_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic               grant_valid_q, grant_valid_d;
  logic               timeout_err_q, timeout_err_d;

  logic [NREQ-1:0]    win;
  logic [IDX_W-1:0]   win_idx;
  logic               any_req;
  logic [GRANT_W-1:0] req_ext;
  logic               owner_req;
  logic               take_grant;
  logic               hold_expired;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt_q, hold_cnt_d;
  assign hold_expired = (hold_cnt_q == HOLD_LAST);
`else
  assign hold_expired = 1'b0;
`endif

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req),
    .ptr     (rr_ptr_q),
    .win     (win),
    .win_idx (win_idx),
    .any     (any_req)
  );

  // The owner index is stored in grant_idx_q; bits above NREQ read as 0.
  assign req_ext   = GRANT_W'(req);
  assign owner_req = req_ext[grant_idx_q];

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    turn_cnt_d    = turn_cnt_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    timeout_err_d = 1'b0;
    take_grant    = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
    hold_cnt_d    = hold_cnt_q;
`endif
    case (state_q)
      IDLE: take_grant = any_req;
      GRANT: begin
        if (!owner_req || hold_expired) begin
          // Owner still requesting means the hold limit forced the release.
          timeout_err_d = owner_req;
          state_d       = TURN;
          turn_cnt_d    = '0;
          grant_d       = '0;
          grant_idx_d   = IDX_NONE;
          grant_valid_d = 1'b0;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
`endif
      end
      TURN: begin
        if (turn_cnt_q == TURN_LAST) begin
          take_grant = any_req;
          if (!any_req) begin
            state_d = IDLE;
          end
        end else begin
          turn_cnt_d = turn_cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take_grant) begin
      state_d       = GRANT;
      grant_d       = GRANT_W'(win);
      grant_idx_d   = win_idx;
      grant_valid_d = 1'b1;
      rr_ptr_d      = wrap_inc(win_idx, LAST_IDX);
`ifdef BUS_ARB_TIMEOUT_EN
      hold_cnt_d    = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      turn_cnt_q    <= '0;
      grant_q       <= '0;
      grant_idx_q   <= IDX_NONE;
      grant_valid_q <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_cnt_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      turn_cnt_q    <= turn_cnt_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      timeout_err_q <= timeout_err_d;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_cnt_q    <= hold_cnt_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb/tb_bus_arbiter_rr.sv - self-checking bench for bus_arbiter_rr against a behavioural model
// Timeout scenarios follow BUS_ARB_TIMEOUT_EN.
module tb_bus_arbiter_rr;

  localparam int NREQ = 24;
  localparam int TURN = 1;
  localparam int MAXH = 16;

  logic            clk = 1'b0;
  logic            clear = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [31:0]     grant;
  logic [4:0]      grant_idx;
  logic            grant_valid;
  logic            timeout_err;

  int checks = 0;
  int failures = 0;

  int m_owner, m_gap, m_ptr, m_hold, m_age;
  bit m_to;
  int seq[$];

  bus_arbiter_rr #(.NREQ(NREQ), .TURN_CYCLES(TURN), .MAX_HOLD(MAXH)) dut (
    .clk         (clk),
    .clear       (clear),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  function automatic int enc(input logic [31:0] g);
    for (int i = 0; i < 32; i++) if (g[i]) return i;
    return 31;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_gap = 0; m_ptr = 0; m_hold = 0; m_age = 0; m_to = 0;
  endtask

  // Round-robin search upward from the pointer with modulo wrap.
  task automatic model_pick(input logic [NREQ-1:0] r);
    int i;
    for (int k = 0; k < NREQ; k++) begin
      i = (m_ptr + k) % NREQ;
      if (r[i]) begin
        m_owner = i; m_ptr = (i + 1) % NREQ; m_hold = 0; m_age = 1;
        seq.push_back(i);
        return;
      end
    end
  endtask

  task automatic model_step(input logic [NREQ-1:0] r);
    m_to = 0;
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_owner = -1; m_gap = TURN;
      end
`ifdef BUS_ARB_TIMEOUT_EN
      else if (m_hold == MAXH - 1) begin
        m_owner = -1; m_gap = TURN; m_to = 1;
      end
`endif
      else begin
        m_hold++; m_age++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0 && r != 0) model_pick(r);
    end else if (r != 0) begin
      model_pick(r);
    end
  endtask

  task automatic check_cycle();
    logic [31:0] exp_g;
    logic [31:0] exp_i;
    exp_g = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    exp_i = (m_owner >= 0) ? 32'(m_owner) : 32'd31;
    check_val("grant", grant, exp_g);
    check_val("grant_idx", 32'(grant_idx), exp_i);
    check_val("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
    check_val("timeout_err", 32'(timeout_err), 32'(m_to));
    check_val("enc_vs_idx", 32'(grant_idx), 32'(enc(grant)));
    check_val("valid_vs_or", 32'(grant_valid), 32'(|grant));
    check_val("onehot", 32'($countones(grant) <= 1), 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    if (!clear) model_reset();
    else model_step(req);
    @(negedge clk);
    check_cycle();
  endtask

  // Called at a negedge; clear falls between edges to exercise the asynchronous path.
  task automatic do_reset();
    #2 clear = 1'b0;
    req = '0;
    #1 model_reset();
    check_cycle();
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    seq.delete();
  endtask

  initial begin
    int held0, pulses, first_other;
    logic [NREQ-1:0] r;

    model_reset();
    repeat (2) @(negedge clk);
    check_cycle();
    check_val("rst_ptr", 32'(dut.rr_ptr_q), 32'd0);
    clear = 1'b1;

    // single requester 2, then release and gap
    req = 24'h000004; step();
    check_val("t1_grant", grant, 32'h4);
    check_val("t1_idx", 32'(grant_idx), 32'd2);
    check_val("t1_valid", 32'(grant_valid), 32'd1);
    req = '0; step();
    check_val("t1_gap", grant, 32'h0);
    step();
    check_val("t1_idle", grant, 32'h0);

    // two requesters alternating, each releases after 3 grant cycles
    do_reset();
    for (int c = 0; c < 40; c++) begin
      r = 24'h000009;
      if (m_owner >= 0 && m_age >= 3) r[m_owner] = 1'b0;
      req = r;
      step();
    end
    check_val("t2_count", 32'(seq.size() >= 4), 32'd1);
    if (seq.size() >= 4) begin
      check_val("t2_seq0", 32'(seq[0]), 32'd0);
      check_val("t2_seq1", 32'(seq[1]), 32'd3);
      check_val("t2_seq2", 32'(seq[2]), 32'd0);
      check_val("t2_seq3", 32'(seq[3]), 32'd3);
    end

    // wrap from the top requester back to 0
    do_reset();
    req = 24'h800000; step();
    check_val("t3_idx23", 32'(grant_idx), 32'd23);
    check_val("t3_ptr_wrap", 32'(dut.rr_ptr_q), 32'd0);
    req = 24'h800001; step();
    req = 24'h000001; step();
    step();
    check_val("t3_idx0", 32'(grant_idx), 32'd0);
    check_val("t3_ptr1", 32'(dut.rr_ptr_q), 32'd1);

    // asynchronous clear in the middle of a grant
    do_reset();
    req = 24'h000020; step(); step();
    check_val("t4_idx5", 32'(grant_idx), 32'd5);
    #2 clear = 1'b0;
    #1;
    check_val("t4_async_grant", grant, 32'h0);
    check_val("t4_async_idx", 32'(grant_idx), 32'd31);
    check_val("t4_async_valid", 32'(grant_valid), 32'd0);
    model_reset();
    req = '0;
    @(negedge clk);
    clear = 1'b1;
    step();
    check_val("t4_ptr", 32'(dut.rr_ptr_q), 32'd0);

`ifdef BUS_ARB_TIMEOUT_EN
    do_reset();
    req = 24'h000003;
    held0 = 0; pulses = 0; first_other = -1;
    for (int c = 0; c < 30; c++) begin
      step();
      if (pulses == 0 && grant_valid && grant_idx == 5'd0) held0++;
      if (timeout_err) pulses++;
      if (first_other < 0 && grant_valid && grant_idx != 5'd0) first_other = int'(grant_idx);
    end
    check_val("t5_held", 32'(held0), 32'(MAXH));
    check_val("t5_pulses", 32'(pulses), 32'd1);
    check_val("t5_next", 32'(first_other), 32'd1);
`else
    do_reset();
    req = 24'h000003;
    step();
    held0 = 0; pulses = 0;
    for (int c = 0; c < 1000; c++) begin
      step();
      if (grant_valid && grant_idx == 5'd0) held0++;
      if (timeout_err) pulses++;
    end
    check_val("t6_held", 32'(held0), 32'd1000);
    check_val("t6_pulses", 32'(pulses), 32'd0);
`endif

    // randomized traffic, owners tend to keep their request for a while
    do_reset();
    for (int c = 0; c < 800; c++) begin
      r = NREQ'($urandom & $urandom);
      if ($urandom_range(7) == 0) r = '0;
      if (m_owner >= 0 && $urandom_range(3) != 0) r[m_owner] = 1'b1;
      req = r;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
